// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit (access sizes, FSM states, byte counts)
package lsu_pkg;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} mem_size_e;
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} lsu_state_e;
  function automatic logic [2:0] size_to_bytes(mem_size_e s);
    return s == SIZE_BYTE ? 3'd1 : s == SIZE_HALF ? 3'd2 : s == SIZE_WORD ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: sizes and sign/zero-extends raw load data; ports data[31:0], size[1:0], uns, result[31:0]
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);
  always_comb
    result = size == SIZE_BYTE ? {{24{~uns & data[7]}}, data[7:0]} :
             size == SIZE_HALF ? {{16{~uns & data[15]}}, data[15:0]} :
             size == SIZE_WORD ? data : '0;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store initiator between execute stage and byte-addressed memory
// Ports: clk, rst (async high); req_valid/req_ready/req_store/req_size/req_unsigned/req_addr/req_wdata;
//   resp_valid/resp_ready/resp_rdata/resp_fault; mem_fetch_addr/mem_write_addr/mem_write_data/
//   mem_bytes_to_write/mem_fetched_data. Parameter READ_LATENCY (0..3).
// Macro LSU_MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of passing them to memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_fetch_addr,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_bytes_to_write,
  input  logic [31:0] mem_fetched_data
);
  lsu_state_e state, state_n;
  mem_size_e size_q;
  logic [31:0] rdata_q, ext;
  logic [1:0] cnt;
  logic uns_q, fault_q, accept, bad, capture;
  assign req_ready = state == IDLE;
  assign accept = req_valid & req_ready;
  assign capture = state == READ && cnt == 2'(READ_LATENCY);
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
`else
  assign bad = req_size == 2'd3;
`endif
  load_extend u_ext (.data(mem_fetched_data), .size(size_q), .uns(uns_q), .result(ext));
  always_comb begin
    state_n = state;
    mem_bytes_to_write = '0;
    state_n = state == IDLE  ? (!accept ? IDLE : bad ? RESP : req_store ? WRITE : READ) :
              state == WRITE ? RESP :
              state == READ  ? (capture ? RESP : READ) :
              resp_ready ? IDLE : RESP;
    mem_bytes_to_write = state == WRITE ? size_to_bytes(size_q) : 3'd0;
  end
  assign resp_valid = state == RESP;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_fault = resp_valid & fault_q;
  // Memory-side address/data registers only move when a request actually uses them.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      size_q <= SIZE_BYTE;
      uns_q <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      cnt <= '0;
      mem_fetch_addr <= '0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
    end else begin
      state <= state_n;
      cnt <= state == READ ? cnt + 2'd1 : 2'd0;
      if (accept) begin
        size_q <= mem_size_e'(req_size);
        uns_q <= req_unsigned;
        fault_q <= bad;
        rdata_q <= '0;
      end
      if (accept && !bad && req_store) begin
        mem_write_addr <= req_addr;
        mem_write_data <= req_wdata;
      end
      if (accept && !bad && !req_store) mem_fetch_addr <= req_addr;
      if (capture) rdata_q <= ext;
    end
endmodule
